// File: rtl/dut_pkg.sv
// Shared types for dut_slave: command encoding, FSM states and storage geometry.
package dut_pkg;

    localparam int unsigned ADR_W  = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 16;

    // Commands 5..15 are illegal and fall outside this enum.
    typedef enum logic [3:0] {
        NOP     = 4'd0,
        WRITE   = 4'd1,
        READ    = 4'd2,
        INC     = 4'd3,
        CLR_ALL = 4'd4
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INC_WB = 2'd1,
        CLEAR  = 2'd2
    } state_e;

endpackage

// File: rtl/dut_slave_regs.sv
// 16 x 4-bit register file: one synchronous write port, one asynchronous read port.
// Every location is forced to CLR_VAL while rst_n is low.
// Ports: clk, rst_n, we/wadr/wdata (write), radr -> rdata_c (combinational read).
module dut_slave_regs
    import dut_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADR_W-1:0]  wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  radr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage with asynchronous clear to CLR_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CLR_VAL;
            end
        end else if (we) begin
            mem_q[wadr] <= wdata;
        end
    end

    assign rdata_c = mem_q[radr];

endmodule

// File: rtl/dut_slave.sv
// Command-driven slave around a 16 x 4-bit store.
// Commands: NOP, WRITE, READ (latency 1), INC (read-modify-write over two cycles),
// CLR_ALL (16-cycle sweep writing CLR_VAL). Commands arriving while busy are dropped
// and counted; illegal commands in IDLE pulse err and are counted. Counters saturate.
// Ports: clk, rst_n, cmd/adr/data (in); rdata, rvalid, busy, err, err_cnt, drop_cnt (out).
module dut_slave
    import dut_pkg::*;
#(
    parameter logic [3:0]  CLR_VAL = 4'h0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       cmd,
    input  logic [3:0]       adr,
    input  logic [3:0]       data,
    output logic [3:0]       rdata,
    output logic             rvalid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [ADR_W-1:0]   sweep_q, sweep_d;
    logic [ADR_W-1:0]   inc_adr_q, inc_adr_d;
    logic [DATA_W-1:0]  inc_val_q, inc_val_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               rvalid_d, busy_d, err_d;
    logic [CNT_W-1:0]   err_cnt_d, drop_cnt_d;

    logic               we;
    logic [ADR_W-1:0]   wadr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rd_c;

    dut_slave_regs #(
        .CLR_VAL (CLR_VAL)
    ) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wadr    (wadr),
        .wdata   (wdata),
        .radr    (adr),
        .rdata_c (rd_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sweep_q   <= '0;
            inc_adr_q <= '0;
            inc_val_q <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            inc_adr_q <= inc_adr_d;
            inc_val_q <= inc_val_d;
            rdata     <= rdata_d;
            rvalid    <= rvalid_d;
            busy      <= busy_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
            drop_cnt  <= drop_cnt_d;
        end
    end

    // Next-state, storage write port and next output values.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        inc_adr_d  = inc_adr_q;
        inc_val_d  = inc_val_q;
        rdata_d    = rdata;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt;
        drop_cnt_d = drop_cnt;
        we         = 1'b0;
        wadr       = adr;
        wdata      = data;

        // Anything but NOP seen while busy is discarded and counted.
        if (state_q != IDLE && cmd != NOP && drop_cnt != CNT_MAX) begin
            drop_cnt_d = drop_cnt + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                case (cmd)
                    NOP: ;
                    WRITE: we = 1'b1;
                    READ: begin
                        rdata_d  = rd_c;
                        rvalid_d = 1'b1;
                    end
                    INC: begin
                        inc_adr_d = adr;
                        inc_val_d = rd_c;
                        state_d   = INC_WB;
                    end
                    CLR_ALL: begin
                        sweep_d = '0;
                        state_d = CLEAR;
                    end
                    default: begin
                        err_d = 1'b1;
                        if (err_cnt != CNT_MAX) begin
                            err_cnt_d = err_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
            INC_WB: begin
                // 4-bit add wraps 15 -> 0 naturally.
                we       = 1'b1;
                wadr     = inc_adr_q;
                wdata    = inc_val_q + DATA_W'(1);
                rdata_d  = inc_val_q + DATA_W'(1);
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            CLEAR: begin
                we      = 1'b1;
                wadr    = sweep_q;
                wdata   = CLR_VAL;
                sweep_d = sweep_q + ADR_W'(1);
                if (sweep_q == ADR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy is registered alongside the state so it tracks INC_WB/CLEAR exactly.
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_dut_slave.sv
// Self-checking bench for dut_slave: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the command semantics.
module tb_dut_slave;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cmd   = 4'd0;
    logic [3:0] adr   = 4'd0;
    logic [3:0] data  = 4'd0;
    logic [3:0] rdata;
    logic       rvalid, busy, err;
    logic [7:0] err_cnt, drop_cnt;

    dut_slave #(
        .CLR_VAL (4'h0),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .adr      (adr),
        .data     (data),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy),
        .err      (err),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int m_mem [16];
    int m_rdata, m_rvalid, m_err, m_err_cnt, m_drop_cnt;
    int m_busy_left, m_inc_pend, m_inc_res;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_rdata = 0; m_rvalid = 0; m_err = 0; m_err_cnt = 0; m_drop_cnt = 0;
        m_busy_left = 0; m_inc_pend = 0; m_inc_res = 0;
    endtask

    // Effect of one sampled command on the model. INC and CLR_ALL take their
    // memory effect at once; only the visible busy window and result timing lag.
    task automatic m_step(input int c, input int a, input int d);
        m_rvalid = 0;
        m_err    = 0;
        if (m_busy_left > 0) begin
            if (c != 0 && m_drop_cnt < 255) m_drop_cnt++;
            if (m_inc_pend != 0) begin
                m_rvalid   = 1;
                m_rdata    = m_inc_res;
                m_inc_pend = 0;
            end
            m_busy_left--;
        end else begin
            case (c)
                0: ;
                1: m_mem[a] = d;
                2: begin m_rvalid = 1; m_rdata = m_mem[a]; end
                3: begin
                    m_inc_res   = (m_mem[a] + 1) % 16;
                    m_mem[a]    = m_inc_res;
                    m_inc_pend  = 1;
                    m_busy_left = 1;
                end
                4: begin
                    foreach (m_mem[i]) m_mem[i] = 0;
                    m_busy_left = 16;
                end
                default: begin
                    m_err = 1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
            endcase
        end
    endtask

    // Drive one command, let the DUT sample it, return at the following negedge.
    task automatic step(input int c, input int a, input int d);
        cmd  = 4'(c);
        adr  = 4'(a);
        data = 4'(d);
        @(posedge clk);
        m_step(c, a, d);
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata",    int'(rdata),    m_rdata);
            chk("rvalid",   int'(rvalid),   m_rvalid);
            chk("busy",     int'(busy),     (m_busy_left > 0) ? 1 : 0);
            chk("err",      int'(err),      m_err);
            chk("err_cnt",  int'(err_cnt),  m_err_cnt);
            chk("drop_cnt", int'(drop_cnt), m_drop_cnt);
        end
    end

    initial begin
        int nb;
        int np;
        int c;
        int r;

        m_reset();
        repeat (2) @(negedge clk);
        chk("reset_rdata",    int'(rdata),    0);
        chk("reset_rvalid",   int'(rvalid),   0);
        chk("reset_busy",     int'(busy),     0);
        chk("reset_err",      int'(err),      0);
        chk("reset_err_cnt",  int'(err_cnt),  0);
        chk("reset_drop_cnt", int'(drop_cnt), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // WRITE then READ of the same location.
        step(1, 5, 9);
        chk("wr_no_rvalid", int'(rvalid), 0);
        step(2, 5, 0);
        chk("wr_rd_rvalid", int'(rvalid), 1);
        chk("wr_rd_rdata",  int'(rdata),  9);
        step(0, 0, 0);
        chk("rvalid_single", int'(rvalid), 0);
        chk("rdata_hold",    int'(rdata),  9);

        // INC wraps 15 -> 0.
        step(1, 3, 15);
        step(3, 3, 0);
        chk("inc_busy",   int'(busy),   1);
        chk("inc_early",  int'(rvalid), 0);
        step(0, 0, 0);
        chk("inc_rvalid", int'(rvalid), 1);
        chk("inc_wrap",   int'(rdata),  0);
        chk("inc_idle",   int'(busy),   0);
        step(2, 3, 0);
        chk("inc_readback", int'(rdata), 0);

        // CLR_ALL over all-7 memory with 3 WRITEs and 1 illegal dropped.
        for (int a = 0; a < 16; a++) step(1, a, 7);
        step(4, 0, 0);
        nb = int'(busy);
        for (int i = 0; i < 16; i++) begin
            c = (i == 2 || i == 5 || i == 9) ? 1 : (i == 12) ? 9 : 0;
            step(c, i, 3);
            nb += int'(busy);
        end
        chk("clr_busy_cycles", nb, 16);
        chk("clr_drop_cnt", int'(drop_cnt), 4);
        chk("clr_err_cnt",  int'(err_cnt),  0);
        for (int a = 0; a < 16; a++) begin
            step(2, a, 0);
            chk("clr_read", int'(rdata), 0);
        end

        // 300 illegal commands saturate err_cnt.
        np = 0;
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(15, 5)), int'($urandom % 16), int'($urandom % 16));
            np += int'(err);
        end
        chk("illegal_pulses", np, 300);
        chk("err_cnt_sat", int'(err_cnt), 255);

        // Reset while the sweep counter is at 6.
        for (int a = 0; a < 16; a++) step(1, a, 7);
        step(4, 0, 0);
        repeat (6) step(0, 0, 0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_clr_busy",   int'(busy),    0);
        chk("rst_clr_rvalid", int'(rvalid),  0);
        chk("rst_clr_errcnt", int'(err_cnt), 0);
        m_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(0, 0, 0);
        chk("rst_clr_no_rvalid", int'(rvalid), 0);
        for (int a = 0; a < 16; a++) begin
            step(2, a, 0);
            chk("rst_clr_read", int'(rdata), 0);
        end

        // Reset while INC writeback is pending.
        step(1, 4, 9);
        step(3, 4, 0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_inc_busy", int'(busy), 0);
        m_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(0, 0, 0);
        chk("rst_inc_no_rvalid", int'(rvalid), 0);
        step(2, 4, 0);
        chk("rst_inc_read", int'(rdata), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom % 20);
            c = (r < 4) ? 0 : (r < 9) ? 1 : (r < 14) ? 2 : (r < 17) ? 3 :
                (r == 17) ? 4 : int'($urandom_range(15, 5));
            step(c, int'($urandom % 16), int'($urandom % 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dut_slave.md
DUT_SLAVE -- requirements
Module: dut_slave

Interface
REQ-001 The parameter CLR_VAL SHALL be declared as: CLR_VAL, 4'h0, value written to every location by CLR_ALL and by reset.
REQ-002 The parameter CNT_W SHALL be declared as: CNT_W, 8, width of the saturating error and drop counters.
REQ-003 The port clk SHALL be declared as: clk  input  1  single clock, all state on posedge.
REQ-004 The port rst_n SHALL be declared as: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The port cmd SHALL be declared as: cmd  input  4  command from the dut_if master side, sampled every posedge.
REQ-006 The port adr SHALL be declared as: adr  input  4  location address 0..15.
REQ-007 The port data SHALL be declared as: data  input  4  write data.
REQ-008 The port rdata SHALL be declared as: rdata  output  4  read or INC result.
REQ-009 The port rvalid SHALL be declared as: rvalid  output  1  one-cycle pulse, rdata valid.
REQ-010 The port busy SHALL be declared as: busy  output  1  high while in INC_WB or CLEAR.
REQ-011 The port err SHALL be declared as: err  output  1  one-cycle pulse on an illegal cmd.
REQ-012 The port err_cnt SHALL be declared as: err_cnt  output  CNT_W  saturating count of illegal cmds.
REQ-013 The port drop_cnt SHALL be declared as: drop_cnt  output  CNT_W  saturating count of non-NOP cmds dropped while busy.

Function
REQ-014 The command encoding SHALL be: 0 NOP, 1 WRITE, 2 READ, 3 INC, 4 CLR_ALL; 5..15 illegal.
REQ-015 Storage SHALL be 16 x 4-bit locations, indexed by adr.
REQ-016 The FSM SHALL have three states: IDLE, INC_WB, CLEAR.
REQ-017 In IDLE, WRITE SHALL update mem[adr] with data at the sampling edge, with no rvalid and no state change.
REQ-018 In IDLE, READ SHALL drive rdata = mem[adr] with rvalid = 1 on the cycle after sampling (latency 1).
REQ-019 A READ immediately following a WRITE to the same adr SHALL return the new data.
REQ-020 In IDLE, INC SHALL capture adr and mem[adr] and move to INC_WB; busy = 1 for exactly one cycle.
REQ-021 In INC_WB, the block SHALL write mem[adr] = mem[adr] + 1 modulo 16 (15 wraps to 0), output the incremented value on rdata with rvalid = 1, and return to IDLE.
REQ-022 In IDLE, CLR_ALL SHALL enter CLEAR, and a 4-bit sweep counter SHALL write CLR_VAL to locations 0..15, one per cycle.
REQ-023 busy SHALL be 1 for exactly 16 cycles during CLEAR; after location 15 the FSM SHALL return to IDLE.
REQ-024 While busy = 1, any non-NOP command (illegal included) SHALL be ignored and SHALL increment drop_cnt; NOP SHALL not be counted.
REQ-025 While busy = 1, an illegal command SHALL not pulse err and SHALL not increment err_cnt.
REQ-026 An illegal command in IDLE SHALL pulse err the next cycle, increment err_cnt, and leave mem unchanged.
REQ-027 err_cnt and drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 rvalid and err SHALL never be high for more than one consecutive cycle per command.
REQ-029 rdata SHALL hold its last value when rvalid = 0.

Reset
REQ-030 When rst_n = 0, the block SHALL immediately set the FSM to IDLE and clear rdata, rvalid, busy, err, err_cnt, drop_cnt and the sweep counter to 0.
REQ-031 While rst_n = 0, every memory location SHALL be set to CLR_VAL.
REQ-032 A reset during INC_WB or CLEAR SHALL abort the operation, leave no partial writeback, and produce no rvalid.
REQ-033 After rst_n deasserts, the first posedge SHALL sample cmd normally.

Structure
REQ-034 The package dut_pkg SHALL hold the cmd enum (NOP, WRITE, READ, INC, CLR_ALL) and the state enum (IDLE, INC_WB, CLEAR).
REQ-035 The storage SHALL be a sub-module dut_slave_regs: 16x4, one write port, one async read port, reset to CLR_VAL.
REQ-036 dut_slave SHALL connect to dut_if through the slave modport (clk, cmd, adr, data).

Verification
REQ-037 Scenario WRITE/READ: WRITE adr 5 data 9, then READ adr 5 -> rvalid 1 cycle after READ, rdata = 9.
REQ-038 Scenario INC wrap: WRITE adr 3 data 15, INC adr 3 -> busy 1 cycle, rdata = 0 with rvalid; a following READ adr 3 returns 0.
REQ-039 Scenario CLR_ALL: WRITE all locations with 7, then CLR_ALL -> busy 16 cycles, all READs return 0.
REQ-040 Scenario drop: issue 3 WRITEs and 1 illegal cmd during CLEAR -> drop_cnt = 4, err_cnt = 0, mem unchanged by them.
REQ-041 Scenario illegal saturation: 300 illegal cmds in IDLE with CNT_W = 8 -> err pulses 300 times, err_cnt = 255.
REQ-042 Scenario reset mid-CLEAR: assert rst_n low at sweep counter 6 -> busy 0 at once, FSM IDLE, all locations CLR_VAL, no rvalid.
